// File: rtl/kore_fetch_decode_if.sv
// Bundles the instruction-memory bus and the issue/eop handshake between the
// fetch/decode sequencer (master) and the memory plus functional FSM (slave).
interface kore_fetch_decode_if #(
  parameter int PC_W = 8
);
  logic            imem_rd;
  logic [PC_W-1:0] imem_addr;
  logic [31:0]     imem_data;
  logic [6:0]      opcode;
  logic [4:0]      pcdata_rs0;
  logic [4:0]      pcdata_rs1;
  logic [4:0]      pcdata_rd;
  logic [2:0]      pcdata_bc;
  logic            opflag;
  logic            eop;

  modport master (
    output imem_rd, imem_addr,
    output opcode, pcdata_rs0, pcdata_rs1, pcdata_rd, pcdata_bc, opflag,
    input  imem_data, eop
  );

  modport slave (
    input  imem_rd, imem_addr,
    input  opcode, pcdata_rs0, pcdata_rs1, pcdata_rd, pcdata_bc, opflag,
    output imem_data, eop
  );
endinterface

// File: rtl/kore_fetch_decode.sv
// Fetch/decode sequencer: fetches words, runs JUMP/HALT locally, issues ALU ops.
// Define KORE_FETCH_TIMEOUT_EN to abort with err after TIMEOUT cycles without eop.
module kore_fetch_decode #(
  parameter int PC_W    = 8,
  parameter int TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  kore_fetch_decode_if.master bus,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [PC_W-1:0]     pc,
  output logic [15:0]         instr_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_DECODE,
    S_ISSUE,
    S_WAIT,
    S_HALT
  } state_t;

  localparam logic [6:0] OP_JUMP = 7'h40;
  localparam logic [6:0] OP_HALT = 7'h7F;
  localparam int         N_ALU   = 4;
  localparam logic [N_ALU*7-1:0] ALU_OPS = {7'h08, 7'h04, 7'h02, 7'h01};

  state_t          state_q, state_d;
  logic [31:0]     ir_q, ir_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [15:0]     cnt_q, cnt_d;
  logic            err_q, err_d;
  logic            eop_q;
  logic [6:0]      opcode_q, opcode_d;
  logic [4:0]      rs0_q, rs0_d;
  logic [4:0]      rs1_q, rs1_d;
  logic [4:0]      rd_q, rd_d;
  logic [2:0]      bc_q, bc_d;

  logic [N_ALU-1:0] alu_hit;
  logic             is_alu;
  logic [6:0]       ir_op;
  logic [PC_W-1:0]  jump_off;
  logic             eop_edge;
  logic             to_expired;

  assign ir_op = ir_q[6:0];

  genvar gi;
  generate
    for (gi = 0; gi < N_ALU; gi++) begin : g_alu
      assign alu_hit[gi] = (ir_op == ALU_OPS[gi*7 +: 7]);
    end
  endgenerate

  assign is_alu   = |alu_hit;
  assign jump_off = PC_W'($signed(ir_q[31:25]));
  // Only a low-to-high transition retires, so a held eop counts once.
  assign eop_edge = bus.eop & ~eop_q;

`ifdef KORE_FETCH_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;

  assign to_cnt_d   = (state_q == S_WAIT) ? to_cnt_q + TO_W'(1) : '0;
  assign to_expired = (to_cnt_q == TO_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT > 0);
  assign to_expired     = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      ir_q     <= '0;
      pc_q     <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      eop_q    <= 1'b0;
      opcode_q <= '0;
      rs0_q    <= '0;
      rs1_q    <= '0;
      rd_q     <= '0;
      bc_q     <= '0;
    end else begin
      state_q  <= state_d;
      ir_q     <= ir_d;
      pc_q     <= pc_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      eop_q    <= bus.eop;
      opcode_q <= opcode_d;
      rs0_q    <= rs0_d;
      rs1_q    <= rs1_d;
      rd_q     <= rd_d;
      bc_q     <= bc_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ir_d     = ir_q;
    pc_d     = pc_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    opcode_d = opcode_q;
    rs0_d    = rs0_q;
    rs1_d    = rs1_q;
    rd_d     = rd_q;
    bc_d     = bc_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          err_d   = 1'b0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        ir_d    = bus.imem_data;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        // Field outputs only move on an ALU word; JUMP/HALT/illegal leave them.
        if (is_alu) begin
          opcode_d = ir_op;
          rd_d     = ir_q[11:7];
          bc_d     = ir_q[14:12];
          rs0_d    = ir_q[19:15];
          rs1_d    = ir_q[24:20];
          state_d  = S_ISSUE;
        end else if (ir_op == OP_JUMP) begin
          pc_d    = pc_q + jump_off;
          state_d = S_FETCH;
        end else begin
          if (ir_op != OP_HALT) begin
            err_d = 1'b1;
          end
          state_d = S_HALT;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (eop_edge) begin
          pc_d    = pc_q + PC_W'(1);
          cnt_d   = cnt_q + 16'd1;
          state_d = S_FETCH;
        end else if (to_expired) begin
          err_d   = 1'b1;
          state_d = S_HALT;
        end
      end
      S_HALT: begin
        if (start) begin
          pc_d    = '0;
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.imem_rd    = (state_q == S_FETCH);
  assign bus.imem_addr  = pc_q;
  assign bus.opflag     = (state_q == S_ISSUE);
  assign bus.opcode     = opcode_q;
  assign bus.pcdata_rs0 = rs0_q;
  assign bus.pcdata_rs1 = rs1_q;
  assign bus.pcdata_rd  = rd_q;
  assign bus.pcdata_bc  = bc_q;

  assign busy      = (state_q != S_IDLE) && (state_q != S_HALT);
  assign done      = (state_q == S_HALT);
  assign err       = err_q;
  assign pc        = pc_q;
  assign instr_cnt = cnt_q;

endmodule
